noc_router_3port: RTL and testbench
===================================

NOC_ROUTER_3PORT -- requirements
Module: noc_router_3port

Interface
REQ-001 Parameter WIDTH, default 16, flit width in bits; SHALL be at least 4.
REQ-002 Parameter DEPTH, default 32, input FIFO depth in entries; SHALL be at least 4.
REQ-003 Parameter ID, default 2'b00, this router's 2-bit node address.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 writeE/writeW/writeL  in  1 each  write strobes into the East/West/Local input FIFOs.
REQ-007 readFullE/readFullW/readFullL  in  1 each  full flag of the downstream FIFO fed by that output port.
REQ-008 read_almostfullE/read_almostfullW/read_almostfullL  in  1 each  almost-full flag of that downstream FIFO.
REQ-009 dataInE/dataInW/dataInL  in  WIDTH each  write data for the matching input FIFO.
REQ-010 dataOutE/dataOutW/dataOutL  out  WIDTH each  registered output flit per port.
REQ-011 writeOutE/writeOutW/writeOutL  out  1 each  registered write strobe qualifying dataOut.
REQ-012 fullE, almost_fullE, fullW, almost_fullW, fullL, almost_fullL  out  1 each  input FIFO status, in that port order.

Function
REQ-013 Destination field SHALL be dataIn[WIDTH-1:WIDTH-2].
REQ-014 Routing SHALL compare dest with ID: dest>ID routes to E; dest<ID routes to W; dest==ID routes to L. Routing SHALL be independent of the arrival port.
REQ-015 An input FIFO write with its write strobe high and full low SHALL store the flit.
REQ-016 A write while full SHALL be dropped, with no state change.
REQ-017 fullX SHALL equal (count==DEPTH).
REQ-018 almost_fullX SHALL equal (count>=DEPTH-2), covering the two flits that can be in flight on a link.
REQ-019 Only the head flit of each non-empty FIFO SHALL request its routed output port.
REQ-020 An output port SHALL be eligible only when both its readFull and read_almostfull inputs are low.
REQ-021 Each eligible output SHALL grant at most one requester per cycle, using round-robin over the order E, W, L.
REQ-022 The round-robin pointer SHALL move to the input after the granted one.
REQ-023 A granted head SHALL be popped in the same cycle.
REQ-024 On a grant, the matching dataOut SHALL register the flit and its writeOut SHALL be 1 for exactly that cycle.
REQ-025 When a port has no grant, its writeOut SHALL be 0 and its dataOut SHALL hold its previous value.
REQ-026 Latency: a flit written at edge k into an empty FIFO with an idle, eligible output SHALL appear with writeOut=1 after edge k+1.
REQ-027 All three outputs SHALL be able to fire in the same cycle when their requests are disjoint.
REQ-028 A simultaneous write and pop on one FIFO SHALL leave the count unchanged.
REQ-029 Pointers SHALL wrap modulo DEPTH.
REQ-030 Per input-output pair, flit order SHALL be preserved.

Reset
REQ-031 While reset is low: all FIFOs empty, every writeOut=0, every dataOut=0, every full and almost_full=0, every round-robin pointer at E.
REQ-032 Reset SHALL take effect immediately, regardless of clk.
REQ-033 Asserting reset mid-traffic SHALL discard all buffered flits.

Structure
REQ-034 A shared package SHALL hold the port index constants E=0, W=1, L=2 and the destination-field position.
REQ-035 One sub-module, noc_fifo, SHALL be instantiated three times. It is a synchronous FIFO (WIDTH, DEPTH) with write, read, data, empty, full and almost_full.
REQ-036 Routing, arbitration and the output registers SHALL sit in the top module.

Verification
REQ-037 Use ID=1, WIDTH=16, DEPTH=32, all read flags 0 unless stated. Assert reset=0 -> all outputs 0; release, then idle -> all writeOut stay 0.
REQ-038 writeL with 16'hC005 -> after 1 cycle writeOutE=1, dataOutE=16'hC005. 16'h0ABC -> writeOutW, dataOutW=16'h0ABC. 16'h4001 -> writeOutL, dataOutL=16'h4001.
REQ-039 read_almostfullE=1, then three dest-3 flits on L -> no writeOutE. Deassert -> 16'hC001, C002, C003 emitted in order on consecutive cycles.
REQ-040 All outputs blocked, 33 writes on L -> almost_fullL=1 at count 30, fullL=1 at 32, 33rd flit lost. Unblock L -> exactly 32 flits out.
REQ-041 Same edge, dest=1 flits on E (16'h4E00) and W (16'h4F00) -> writeOutL fires 2 consecutive cycles: 16'h4E00 then 16'h4F00. Meanwhile a 16'hC0AA written on L on that edge exits E in the first of those cycles.
REQ-042 Assert reset with 5 flits buffered -> all outputs 0 immediately; after release, no stale flits emerge.

Source files
------------

// File: rtl/noc_router_3port_pkg.sv
// Shared constants and helpers for the 3-port NoC router.
package noc_router_3port_pkg;

   localparam int NPORTS = 3;

   // Port indices, also the round-robin scan order.
   localparam logic [1:0] PORT_E = 2'd0;
   localparam logic [1:0] PORT_W = 2'd1;
   localparam logic [1:0] PORT_L = 2'd2;

   // The destination address occupies the top DEST_W bits of a flit.
   localparam int DEST_W = 2;

   // Output port for a destination, seen from the node with address id.
   function automatic logic [1:0] route_port(input logic [DEST_W-1:0] dest,
                                             input logic [DEST_W-1:0] id);
      if (dest > id) return PORT_E;
      if (dest < id) return PORT_W;
      return PORT_L;
   endfunction

   // Next port in round-robin order E -> W -> L -> E.
   function automatic logic [1:0] rr_next(input logic [1:0] p);
      return (p == PORT_L) ? PORT_E : p + 2'd1;
   endfunction

endpackage

// File: rtl/noc_router_3port_fifo.sv
// Synchronous input FIFO; the head entry is visible combinationally on data_o.
module noc_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_i,
   input  logic             rd_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             almost_full_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             wr_en, rd_en;

   // Writes into a full FIFO are dropped; reads from an empty one are ignored.
   assign wr_en         = wr_i && !full_o;
   assign rd_en         = rd_i && !empty_o;
   assign data_o        = mem_q[rptr_q];
   assign empty_o       = (cnt_q == '0);
   assign full_o        = (cnt_q == CW'(DEPTH));
   assign almost_full_o = (cnt_q >= CW'(DEPTH - 2));

   // Next pointers wrap at DEPTH so non-power-of-two depths also work.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (wr_en) wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (rd_en) rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
   end

   // Storage array needs no reset; only occupied entries are ever read out.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wptr_q] <= data_i;
   end

   // Pointer and occupancy state; reset empties the FIFO.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/noc_router_3port.sv
// 3-port (E/W/L) NoC router: input FIFOs, destination routing,
// per-output round-robin arbitration and registered outputs.
module noc_router_3port
   import noc_router_3port_pkg::*;
#(
   parameter int         WIDTH = 16,
   parameter int         DEPTH = 32,
   parameter logic [1:0] ID    = 2'b00
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             writeE,
   input  logic             writeW,
   input  logic             writeL,
   input  logic             readFullE,
   input  logic             readFullW,
   input  logic             readFullL,
   input  logic             read_almostfullE,
   input  logic             read_almostfullW,
   input  logic             read_almostfullL,
   input  logic [WIDTH-1:0] dataInE,
   input  logic [WIDTH-1:0] dataInW,
   input  logic [WIDTH-1:0] dataInL,
   output logic [WIDTH-1:0] dataOutE,
   output logic [WIDTH-1:0] dataOutW,
   output logic [WIDTH-1:0] dataOutL,
   output logic             writeOutE,
   output logic             writeOutW,
   output logic             writeOutL,
   output logic             fullE,
   output logic             almost_fullE,
   output logic             fullW,
   output logic             almost_fullW,
   output logic             fullL,
   output logic             almost_fullL
);
   logic [NPORTS-1:0]             wr, empty, full, afull, pop, elig;
   logic [NPORTS-1:0][WIDTH-1:0]  din, head;
   logic [NPORTS-1:0][NPORTS-1:0] req;                // req[out][in]
   logic [NPORTS-1:0][1:0]        rr_q, rr_d;
   logic [NPORTS-1:0][WIDTH-1:0]  dout_q, dout_d;
   logic [NPORTS-1:0]             wout_q, wout_d;

   assign wr   = {writeL, writeW, writeE};
   assign din  = {dataInL, dataInW, dataInE};
   // Back off while the downstream FIFO is full or almost full, leaving room for in-flight flits.
   assign elig = ~({readFullL, readFullW, readFullE} |
                   {read_almostfullL, read_almostfullW, read_almostfullE});

   for (genvar p = 0; p < NPORTS; p++) begin : g_fifo
      noc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
         .clk_i        (clk),
         .rst_ni       (reset),
         .wr_i         (wr[p]),
         .rd_i         (pop[p]),
         .data_i       (din[p]),
         .data_o       (head[p]),
         .empty_o      (empty[p]),
         .full_o       (full[p]),
         .almost_full_o(afull[p])
      );
   end

   // Each non-empty head requests the one output its destination selects.
   always_comb begin
      req = '0;
      for (int i = 0; i < NPORTS; i++)
         if (!empty[i]) req[route_port(head[i][WIDTH-1 -: DEST_W], ID)][i] = 1'b1;
   end

   // Round-robin grant per output starting at rr_q; a grant pops its head the same cycle.
   always_comb begin
      logic [1:0] cand;
      logic       found;
      rr_d   = rr_q;
      dout_d = dout_q;
      wout_d = '0;
      pop    = '0;
      cand   = PORT_E;
      found  = 1'b0;
      for (int o = 0; o < NPORTS; o++) begin
         cand  = rr_q[o];
         found = 1'b0;
         for (int k = 0; k < NPORTS; k++) begin
            if (elig[o] && !found && req[o][cand]) begin
               found     = 1'b1;
               wout_d[o] = 1'b1;
               dout_d[o] = head[cand];
               pop[cand] = 1'b1;
               rr_d[o]   = rr_next(cand);
            end
            cand = rr_next(cand);
         end
      end
   end

   // Output registers and arbitration pointers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_q   <= {NPORTS{PORT_E}};
         dout_q <= '0;
         wout_q <= '0;
      end else begin
         rr_q   <= rr_d;
         dout_q <= dout_d;
         wout_q <= wout_d;
      end
   end

   assign dataOutE     = dout_q[PORT_E];
   assign dataOutW     = dout_q[PORT_W];
   assign dataOutL     = dout_q[PORT_L];
   assign writeOutE    = wout_q[PORT_E];
   assign writeOutW    = wout_q[PORT_W];
   assign writeOutL    = wout_q[PORT_L];
   assign fullE        = full[PORT_E];
   assign fullW        = full[PORT_W];
   assign fullL        = full[PORT_L];
   assign almost_fullE = afull[PORT_E];
   assign almost_fullW = afull[PORT_W];
   assign almost_fullL = afull[PORT_L];

endmodule

// File: tb/tb_noc_router_3port.sv
// Self-checking bench for noc_router_3port (ID=1, WIDTH=16, DEPTH=32).
module tb_noc_router_3port;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [2:0]       wr = '0, rf = '0, raf = '0;
   logic [2:0][15:0] din = '0;
   logic [2:0][15:0] dout;
   logic [2:0]       wo, full_v, af_v, fired;

   logic [15:0] qE[$], qW[$], qL[$];
   int n_cmp = 0, n_bad = 0;

   typedef struct {
      int          in_port;
      logic [15:0] data;
      int          out_port;
   } vec_t;
   vec_t vecs[7];

   always #5 clk = ~clk;

   noc_router_3port #(.WIDTH(16), .DEPTH(32), .ID(2'b01)) dut (
      .clk(clk), .reset(rst_n),
      .writeE(wr[0]), .writeW(wr[1]), .writeL(wr[2]),
      .readFullE(rf[0]), .readFullW(rf[1]), .readFullL(rf[2]),
      .read_almostfullE(raf[0]), .read_almostfullW(raf[1]), .read_almostfullL(raf[2]),
      .dataInE(din[0]), .dataInW(din[1]), .dataInL(din[2]),
      .dataOutE(dout[0]), .dataOutW(dout[1]), .dataOutL(dout[2]),
      .writeOutE(wo[0]), .writeOutW(wo[1]), .writeOutL(wo[2]),
      .fullE(full_v[0]), .almost_fullE(af_v[0]),
      .fullW(full_v[1]), .almost_fullW(af_v[1]),
      .fullL(full_v[2]), .almost_fullL(af_v[2])
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int p, input logic [15:0] d);
      case (p)
         0:       qE.push_back(d);
         1:       qW.push_back(d);
         default: qL.push_back(d);
      endcase
   endtask

   // Scoreboard: every emitted flit must match the oldest expected flit for that port.
   task automatic check_out(input int p, input logic [15:0] d);
      logic [15:0] e;
      int          sz;
      sz = (p == 0) ? qE.size() : (p == 1) ? qW.size() : qL.size();
      n_cmp++;
      if (sz == 0) begin
         n_bad++;
         $display("FAIL unexpected_out port %0d: got %h expected no flit", p, d);
      end else begin
         case (p)
            0:       e = qE.pop_front();
            1:       e = qW.pop_front();
            default: e = qL.pop_front();
         endcase
         if (d !== e) begin
            n_bad++;
            $display("FAIL out_data port %0d: got %h expected %h", p, d, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      fired = wo;
      for (int p = 0; p < 3; p++) if (wo[p]) check_out(p, dout[p]);
   endtask

   task automatic clear_q();
      qE.delete(); qW.delete(); qL.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wr = '0; rf = '0; raf = '0;
      #1;
      clear_q();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic drain(input string name, input int bound);
      for (int c = 0; c < bound && (qE.size() + qW.size() + qL.size()) > 0; c++) tick();
      chk(name, 64'(qE.size() + qW.size() + qL.size()), 64'd0);
   endtask

   initial begin
      int cnt;
      vecs[0] = '{2, 16'hC005, 0};
      vecs[1] = '{2, 16'h0ABC, 1};
      vecs[2] = '{2, 16'h4001, 2};
      vecs[3] = '{0, 16'h8123, 0};
      vecs[4] = '{1, 16'h0F0F, 1};
      vecs[5] = '{0, 16'h7FFF, 2};
      vecs[6] = '{1, 16'hBEEF, 0};

      // Reset state and idle behaviour.
      #3;
      chk("reset_status", {wo, full_v, af_v}, 64'd0);
      chk("reset_dout", 64'(dout), 64'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle_writeout", 64'(fired), 64'd0);
      end

      // Routing and one-cycle latency, table-driven.
      foreach (vecs[i]) begin
         wr[vecs[i].in_port]  = 1'b1;
         din[vecs[i].in_port] = vecs[i].data;
         push_exp(vecs[i].out_port, vecs[i].data);
         tick();
         wr = '0;
         chk("vec_write_edge", 64'(fired), 64'd0);
         tick();
         chk("vec_route", 64'(fired), 64'(3'b001 << vecs[i].out_port));
         tick();
      end

      // Almost-full backpressure on E, then in-order release on consecutive cycles.
      raf[0] = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         wr[2] = 1'b1; din[2] = 16'hC000 + 16'(i);
         push_exp(0, din[2]);
         tick();
      end
      wr = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("blocked_E", 64'(fired[0]), 64'd0);
      end
      raf[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("release_E", 64'(fired[0]), (i < 3) ? 64'd1 : 64'd0);
      end
      chk("release_E_empty", 64'(qE.size()), 64'd0);

      // Fill L to full with all outputs blocked; the 33rd write is lost.
      rf = 3'b111;
      for (int i = 1; i <= 33; i++) begin
         wr[2] = 1'b1; din[2] = 16'h4000 + 16'(i);
         if (i <= 32) push_exp(2, din[2]);
         tick();
         cnt = (i > 32) ? 32 : i;
         chk("almost_fullL", 64'(af_v[2]), (cnt >= 30) ? 64'd1 : 64'd0);
         chk("fullL", 64'(full_v[2]), (cnt == 32) ? 64'd1 : 64'd0);
      end
      wr = '0;
      rf[2] = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (fired[2]) cnt++;
      end
      chk("drained_count_L", 64'(cnt), 64'd32);
      chk("L_status_after_drain", {62'd0, full_v[2], af_v[2]}, 64'd0);
      rf = '0;
      drain("drain_after_fill", 10);

      // Contention on L from E and W, with a disjoint flit to E on the same edge.
      do_reset();
      wr = 3'b111;
      din[0] = 16'h4E00; din[1] = 16'h4F00; din[2] = 16'hC0AA;
      push_exp(2, 16'h4E00); push_exp(2, 16'h4F00); push_exp(0, 16'hC0AA);
      tick();
      wr = '0;
      chk("contend_write_edge", 64'(fired), 64'd0);
      tick();
      chk("contend_first", 64'(fired), 64'b101);
      tick();
      chk("contend_second", 64'(fired), 64'b100);
      tick();
      chk("contend_idle", 64'(fired), 64'd0);
      drain("drain_contend", 5);

      // Asynchronous reset with buffered flits discards them.
      rf = 3'b111;
      for (int i = 0; i < 5; i++) begin
         wr = 3'b100; din[2] = (i % 2 == 0) ? 16'hC100 + 16'(i) : 16'h4100 + 16'(i);
         tick();
      end
      wr = '0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_status", {wo, full_v, af_v}, 64'd0);
      chk("async_reset_dout", 64'(dout), 64'd0);
      clear_q();
      tick();
      rst_n = 1'b1;
      rf = '0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("no_stale_flits", 64'(fired), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
